dot_product_sequencer: RTL and testbench

- Upstream control stage for the fused multiply-add (FMA) accumulator in the matrix processor.
- Accepts a dot-product command (length, two operand base addresses, seed).
- Streams element pairs from two synchronous-read operand memories into the FMA, driving `a`, `b`, `seed`, `updateAccumulator` and `en` directly.
- Captures the final accumulator value and returns it on a valid/ready result port.

---
 rtl/dotseq_pkg.sv | 22 ++
 rtl/dotseq_addr_gen.sv | 45 ++++
 rtl/dot_product_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_dot_product_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dotseq_pkg.sv
// Shared types and constants for the dot-product sequencer.
// The optional DOTSEQ_STRIDE_EN build adds per-operand address strides.
package dotseq_pkg;

  // Default widths; the FMA must be built with the same WIDTH.
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_LEN_W  = 8;

  // Edges from command accept to res_valid beyond the element count N.
  localparam int LAT_OVERHEAD = 3;

  // Sequencer control states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    DRAIN   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/dotseq_addr_gen.sv
// Operand address generator: loads base/stride on start and advances by the
// stride on each issued read, wrapping modulo 2^ADDR_W.
module dotseq_addr_gen #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] stride_d;

  // Next address: reload on start, otherwise add the latched stride per issue.
  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    if (start_i) begin
      addr_d   = base_i;
      stride_d = stride_i;
    end else if (step_i) begin
      addr_d = addr_q + stride_q;
    end
  end

  // Address and stride registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      stride_q <= '0;
    end else begin
      addr_q   <= addr_d;
      stride_q <= stride_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/dot_product_sequencer.sv
// Dot-product sequencer: streams operand pairs from two synchronous-read
// memories into the FMA accumulator and returns the final sum on a
// valid/ready port. Optional build macro: DOTSEQ_STRIDE_EN (per-operand
// address strides; without it the stride is fixed at 1).
module dot_product_sequencer
  import dotseq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_base_a,
  input  logic [ADDR_W-1:0] cmd_base_b,
  input  logic [WIDTH-1:0]  cmd_seed,
`ifdef DOTSEQ_STRIDE_EN
  input  logic [ADDR_W-1:0] cmd_stride_a,
  input  logic [ADDR_W-1:0] cmd_stride_b,
`endif
  output logic              mem_a_ren,
  output logic [ADDR_W-1:0] mem_a_addr,
  input  logic [WIDTH-1:0]  mem_a_data,
  output logic              mem_b_ren,
  output logic [ADDR_W-1:0] mem_b_addr,
  input  logic [WIDTH-1:0]  mem_b_data,
  output logic [WIDTH-1:0]  fma_a,
  output logic [WIDTH-1:0]  fma_b,
  output logic [WIDTH-1:0]  fma_seed,
  output logic              fma_update,
  output logic              fma_en,
  input  logic [WIDTH-1:0]  fma_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_data,
  output logic              busy
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   k_q;
  logic [LEN_W-1:0]   len_q;
  logic [WIDTH-1:0]   seed_q;
  logic               en_q;
  logic               upd_q;
  logic               rd_vld_q;
  logic [WIDTH-1:0]   res_q;

  logic               accept;
  logic               issue;
  logic               last_issue;
  logic               zero_len;
  logic [ADDR_W-1:0]  stride_a;
  logic [ADDR_W-1:0]  stride_b;

  assign accept     = cmd_valid && (state_q == IDLE);
  assign issue      = (state_q == ISSUE);
  assign last_issue = issue && (k_q == (len_q - LEN_ONE));
  assign zero_len   = (cmd_len == '0);

`ifdef DOTSEQ_STRIDE_EN
  assign stride_a = cmd_stride_a;
  assign stride_b = cmd_stride_b;
`else
  assign stride_a = ADDR_W'(1);
  assign stride_b = ADDR_W'(1);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control outputs. A zero-length command skips ISSUE and
  // goes straight to DRAIN so its single seed-only FMA cycle keeps the same
  // N+3 latency as a real run.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    mem_a_ren = 1'b0;
    mem_b_ren = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_d = zero_len ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        mem_a_ren = 1'b1;
        mem_b_ren = 1'b1;
        if (last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latches, element counter, FMA strobe pipeline and result register.
  // en/update are delayed one cycle so they line up with the memory data;
  // rd_vld_q marks cycles where that data came from a real read, which keeps
  // the operands at zero for the seed-only cycle of a zero-length command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q      <= '0;
      len_q    <= '0;
      seed_q   <= '0;
      en_q     <= 1'b0;
      upd_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      res_q    <= '0;
    end else begin
      en_q     <= issue || (accept && zero_len);
      upd_q    <= (issue && (k_q == '0)) || (accept && zero_len);
      rd_vld_q <= issue;
      if (accept) begin
        k_q    <= '0;
        len_q  <= cmd_len;
        seed_q <= cmd_seed;
      end else if (issue) begin
        k_q <= k_q + LEN_ONE;
      end
      if (state_q == CAPTURE) begin
        res_q <= fma_acc;
      end
    end
  end

  dotseq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept),
    .base_i   (cmd_base_a),
    .stride_i (stride_a),
    .step_i   (issue),
    .addr_o   (mem_a_addr)
  );

  dotseq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept),
    .base_i   (cmd_base_b),
    .stride_i (stride_b),
    .step_i   (issue),
    .addr_o   (mem_b_addr)
  );

  assign fma_a      = (en_q && rd_vld_q) ? mem_a_data : '0;
  assign fma_b      = (en_q && rd_vld_q) ? mem_b_data : '0;
  assign fma_en     = en_q;
  assign fma_update = upd_q;
  assign fma_seed   = seed_q;
  assign res_data   = res_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed testbench for dot_product_sequencer with behavioural operand
// memories and FMA accumulator. Honours DOTSEQ_STRIDE_EN when defined.
module tb_dot_product_sequencer;
  import dotseq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_len;
  logic [9:0]  cmd_base_a;
  logic [9:0]  cmd_base_b;
  logic [31:0] cmd_seed;
`ifdef DOTSEQ_STRIDE_EN
  logic [9:0]  cmd_stride_a;
  logic [9:0]  cmd_stride_b;
`endif
  logic        mem_a_ren;
  logic [9:0]  mem_a_addr;
  logic [31:0] mem_a_data;
  logic        mem_b_ren;
  logic [9:0]  mem_b_addr;
  logic [31:0] mem_b_data;
  logic [31:0] fma_a;
  logic [31:0] fma_b;
  logic [31:0] fma_seed;
  logic        fma_update;
  logic        fma_en;
  logic [31:0] fma_acc;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];

  int errors = 0;
  int checks = 0;

  dot_product_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_base_a (cmd_base_a),
    .cmd_base_b (cmd_base_b),
    .cmd_seed   (cmd_seed),
`ifdef DOTSEQ_STRIDE_EN
    .cmd_stride_a (cmd_stride_a),
    .cmd_stride_b (cmd_stride_b),
`endif
    .mem_a_ren  (mem_a_ren),
    .mem_a_addr (mem_a_addr),
    .mem_a_data (mem_a_data),
    .mem_b_ren  (mem_b_ren),
    .mem_b_addr (mem_b_addr),
    .mem_b_data (mem_b_data),
    .fma_a      (fma_a),
    .fma_b      (fma_b),
    .fma_seed   (fma_seed),
    .fma_update (fma_update),
    .fma_en     (fma_en),
    .fma_acc    (fma_acc),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read operand memories.
  always @(posedge clk) begin
    if (mem_a_ren) mem_a_data <= mem_a[mem_a_addr];
    if (mem_b_ren) mem_b_data <= mem_b[mem_b_addr];
  end

  // FMA accumulator: update reseeds, en accumulates a*b.
  initial fma_acc = '0;
  always @(posedge clk) begin
    if (fma_en) fma_acc <= (fma_update ? fma_seed : fma_acc) + fma_a * fma_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command at a negedge and check every cycle against the fixed
  // timing: reads in 1..N, en in 2..N+1 (cycle 1 for N=0), res_valid from N+3.
  task automatic run(input string nm, input int n, input logic [9:0] ba, input logic [9:0] bb,
                     input logic [31:0] seed, input logic [9:0] sa, input logic [9:0] sb,
                     input logic [31:0] exp_res, input int hold, input bit keep_valid);
    logic        e_ren, e_en, e_upd, e_rv;
    logic [9:0]  ea, eb;
    logic [31:0] e_fa, e_fb;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_len    = 8'(n);
    cmd_base_a = ba;
    cmd_base_b = bb;
    cmd_seed   = seed;
`ifdef DOTSEQ_STRIDE_EN
    cmd_stride_a = sa;
    cmd_stride_b = sb;
`endif
    res_ready  = (hold == 0);
    check({nm, ".c0.cmd_ready"}, 32'(cmd_ready), 32'd1);
    for (int c = 1; c <= n + LAT_OVERHEAD + hold; c++) begin
      @(negedge clk);
      if (!keep_valid) cmd_valid = 1'b0;
      e_ren = (c >= 1) && (c <= n);
      e_en  = (n == 0) ? (c == 1) : ((c >= 2) && (c <= n + 1));
      e_upd = (n == 0) ? (c == 1) : (c == 2);
      e_rv  = (c >= n + LAT_OVERHEAD);
      ea = ba + 10'(c - 1) * sa;
      eb = bb + 10'(c - 1) * sb;
      e_fa = 32'd0;
      e_fb = 32'd0;
      if (n > 0 && e_en) begin
        e_fa = mem_a[ba + 10'(c - 2) * sa];
        e_fb = mem_b[bb + 10'(c - 2) * sb];
      end
      check($sformatf("%s.c%0d.ren_a", nm, c), 32'(mem_a_ren), 32'(e_ren));
      check($sformatf("%s.c%0d.ren_b", nm, c), 32'(mem_b_ren), 32'(e_ren));
      if (e_ren) begin
        check($sformatf("%s.c%0d.addr_a", nm, c), 32'(mem_a_addr), 32'(ea));
        check($sformatf("%s.c%0d.addr_b", nm, c), 32'(mem_b_addr), 32'(eb));
      end
      check($sformatf("%s.c%0d.fma_en", nm, c), 32'(fma_en), 32'(e_en));
      check($sformatf("%s.c%0d.fma_upd", nm, c), 32'(fma_update), 32'(e_upd));
      check($sformatf("%s.c%0d.fma_a", nm, c), fma_a, e_fa);
      check($sformatf("%s.c%0d.fma_b", nm, c), fma_b, e_fb);
      check($sformatf("%s.c%0d.busy", nm, c), 32'(busy), 32'd1);
      check($sformatf("%s.c%0d.cmd_ready", nm, c), 32'(cmd_ready), 32'd0);
      check($sformatf("%s.c%0d.res_valid", nm, c), 32'(res_valid), 32'(e_rv));
      if (e_en) check($sformatf("%s.c%0d.fma_seed", nm, c), fma_seed, seed);
      if (e_rv) check($sformatf("%s.c%0d.res_data", nm, c), res_data, exp_res);
      if (c == n + LAT_OVERHEAD + hold) res_ready = 1'b1;
    end
    @(negedge clk);
    check({nm, ".post.cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({nm, ".post.busy"}, 32'(busy), 32'd0);
    check({nm, ".post.res_valid"}, 32'(res_valid), 32'd0);
    $display("txn %s: N=%0d seed=%0d result=%0d expected=%0d", nm, n, seed, res_data, exp_res);
  endtask

  initial begin
    int  lat;
    bit  seen;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_len    = '0;
    cmd_base_a = '0;
    cmd_base_b = '0;
    cmd_seed   = '0;
`ifdef DOTSEQ_STRIDE_EN
    cmd_stride_a = '0;
    cmd_stride_b = '0;
`endif
    res_ready  = 1'b0;
    mem_a_data = '0;
    mem_b_data = '0;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 32'd0;
      mem_b[i] = 32'd0;
    end
    mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3; mem_a[4] = 7; mem_a[1023] = 5; mem_a[300] = 3;
    mem_b[0] = 2; mem_b[100] = 4; mem_b[101] = 5; mem_b[102] = 6;
    mem_b[200] = 1; mem_b[201] = 1; mem_b[202] = 1; mem_b[300] = 3;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst.cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.ren_a", 32'(mem_a_ren), 32'd0);
    check("rst.ren_b", 32'(mem_b_ren), 32'd0);
    check("rst.addr_a", 32'(mem_a_addr), 32'd0);
    check("rst.addr_b", 32'(mem_b_addr), 32'd0);
    check("rst.fma_en", 32'(fma_en), 32'd0);
    check("rst.fma_upd", 32'(fma_update), 32'd0);
    check("rst.fma_seed", fma_seed, 32'd0);
    check("rst.res_valid", 32'(res_valid), 32'd0);
    check("rst.res_data", res_data, 32'd0);
    rst_n = 1'b1;

    // 10 + 1*4 + 2*5 + 3*6 = 42
    run("n3", 3, 10'd0, 10'd100, 32'd10, 10'd1, 10'd1, 32'd42, 0, 1'b0);
    // Zero length: accumulator becomes the seed.
    run("n0", 0, 10'd0, 10'd100, 32'd7, 10'd1, 10'd1, 32'd7, 0, 1'b0);
    // A wraps 1023,0,1: 5 + 1 + 2 = 8
    run("wrap", 3, 10'd1023, 10'd200, 32'd0, 10'd1, 10'd1, 32'd8, 0, 1'b0);

    // Back-pressure: res_ready low 5 cycles, cmd_valid held; 1*4 + 2*5 = 14
    run("hold", 2, 10'd0, 10'd100, 32'd0, 10'd1, 10'd1, 32'd14, 5, 1'b1);
    // The held command is accepted on the edge after cmd_ready rose.
    @(negedge clk);
    cmd_valid = 1'b0;
    check("hold2.busy", 32'(busy), 32'd1);
    check("hold2.ren_a", 32'(mem_a_ren), 32'd1);
    check("hold2.addr_a", 32'(mem_a_addr), 32'd0);
    seen = 1'b0;
    lat  = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("hold2.res_seen", 32'(seen), 32'd1);
    check("hold2.latency", 32'(lat), 32'(2 + LAT_OVERHEAD));
    check("hold2.res_data", res_data, 32'd14);
    $display("txn hold2: N=2 seed=0 result=%0d expected=14", res_data);
    @(negedge clk);
    check("hold2.post.cmd_ready", 32'(cmd_ready), 32'd1);

    // Reset in cycle 2 of an N=5 run.
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_len    = 8'd5;
    cmd_base_a = 10'd0;
    cmd_base_b = 10'd100;
    cmd_seed   = 32'd0;
`ifdef DOTSEQ_STRIDE_EN
    cmd_stride_a = 10'd1;
    cmd_stride_b = 10'd1;
`endif
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rstmid.c1.ren_a", 32'(mem_a_ren), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid.ren_a", 32'(mem_a_ren), 32'd0);
    check("rstmid.ren_b", 32'(mem_b_ren), 32'd0);
    check("rstmid.fma_en", 32'(fma_en), 32'd0);
    check("rstmid.fma_upd", 32'(fma_update), 32'd0);
    check("rstmid.cmd_ready", 32'(cmd_ready), 32'd1);
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.res_valid", 32'(res_valid), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("rstmid.no_result", 32'(seen), 32'd0);
    $display("txn rstmid: N=5 aborted by reset");
    // 0 + 3*3 = 9
    run("after_rst", 1, 10'd300, 10'd300, 32'd0, 10'd1, 10'd1, 32'd9, 0, 1'b0);

`ifdef DOTSEQ_STRIDE_EN
    // A at 0,2,4 = 1,3,7; B at 0 = 2: 1 + 2*11 = 23
    run("stride", 3, 10'd0, 10'd0, 32'd1, 10'd2, 10'd0, 32'd23, 0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
